// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared counter/FSM types and the saturating counter helpers
// for the branch predictor.
package bpu_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } bpu_state_e;

  function automatic ctr_e ctr_update(input ctr_e c, input logic taken);
    ctr_e r;
    r = c;
    if (taken && (c != STRONG_T)) begin
      r = ctr_e'(c + 2'd1);
    end else if (!taken && (c != STRONG_NT)) begin
      r = ctr_e'(c - 2'd1);
    end
    return r;
  endfunction

  // Unconditional jumps start fully confident; conditional branches start weak.
  function automatic ctr_e ctr_alloc(input logic is_jump);
    return is_jump ? STRONG_T : WEAK_T;
  endfunction

endpackage

// File: rtl/bpu_table.sv
// rtl/bpu_table.sv - predictor entry storage: combinational fetch read port and
// one synchronous read-modify-write update port.
module bpu_table
  import bpu_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int TAG_W  = PC_W - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             rd_hit_o,
  output ctr_e             rd_ctr_o,
  output logic [PC_W-1:0]  rd_target_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_taken_i,
  input  logic             wr_jump_i,
  input  logic [PC_W-1:0]  wr_target_i
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    ctr_e             ctr;
  } entry_t;

  entry_t mem_q [ENTRIES];
  entry_t rd_e;
  entry_t wr_e;
  entry_t wr_d;
  logic   wr_hit;
  logic   wr_commit;

  // Reads see the registered contents, so a same-cycle update is not bypassed.
  always_comb begin
    rd_e        = mem_q[rd_idx_i];
    rd_hit_o    = rd_e.valid && (rd_e.tag == rd_tag_i);
    rd_ctr_o    = rd_e.ctr;
    rd_target_o = rd_e.target;
  end

  always_comb begin
    wr_e   = mem_q[wr_idx_i];
    wr_hit = wr_e.valid && (wr_e.tag == wr_tag_i);
    wr_d   = wr_e;
    if (wr_hit) begin
      wr_d.ctr = ctr_update(wr_e.ctr, wr_taken_i);
      if (wr_taken_i) begin
        wr_d.target = wr_target_i;
      end
    end else begin
      wr_d.valid  = 1'b1;
      wr_d.tag    = wr_tag_i;
      wr_d.target = wr_target_i;
      wr_d.ctr    = ctr_alloc(wr_jump_i);
    end
  end

  // A not-taken miss leaves the table alone.
  assign wr_commit = wr_en_i && (wr_hit || wr_taken_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
      end
    end else if (wr_commit) begin
      mem_q[wr_idx_i] <= wr_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - branch resolve, redirect, halt FSM and optional
// performance counters (enabled by BPU_PERF_CNT_EN) around the bpu_table.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            ex_halt,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic [31:0]     pc_four,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic            j_sel,
  output logic            halted
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mis_cnt
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  bpu_state_e      state_q, state_d;
  logic [PC_W-1:0] halt_pc_q, halt_pc_d;

  logic            rd_hit;
  ctr_e            rd_ctr;
  logic [PC_W-1:0] rd_target;

  logic [31:0]     ex_pc_ext;
  logic [31:0]     target;
  logic            actual_taken;
  logic            is_jump;
  logic            mispredict;
  logic            upd_en;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = ^fetch_pc[1:0];

  bpu_table #(
    .PC_W    (PC_W),
    .ENTRIES (ENTRIES)
  ) u_table (
    .clk         (clk),
    .rst         (reset),
    .rd_idx_i    (fetch_pc[IDX_W+1:2]),
    .rd_tag_i    (fetch_pc[PC_W-1:IDX_W+2]),
    .rd_hit_o    (rd_hit),
    .rd_ctr_o    (rd_ctr),
    .rd_target_o (rd_target),
    .wr_en_i     (upd_en),
    .wr_idx_i    (ex_pc[IDX_W+1:2]),
    .wr_tag_i    (ex_pc[PC_W-1:IDX_W+2]),
    .wr_taken_i  (actual_taken),
    .wr_jump_i   (is_jump),
    .wr_target_i (target[PC_W-1:0])
  );

  assign halted      = (state_q == HALTED);
  assign pred_taken  = rd_hit && rd_ctr[1] && !halted;
  assign pred_target = rd_hit ? rd_target : '0;

  assign ex_pc_ext    = {{(32-PC_W){1'b0}}, ex_pc};
  assign pc_four      = ex_pc_ext + 32'd4;
  assign j_sel        = ex_jal | ex_jalr;
  assign is_jump      = ex_jal | ex_jalr;
  assign actual_taken = (ex_branch & ex_alu_result[0]) | ex_jal | ex_jalr;
  assign target       = ex_jalr ? ex_alu_result : (ex_pc_ext + ex_imm);

  // The carried-down target only matters when the instruction really was taken.
  assign mispredict = ex_valid &&
                      ((actual_taken != ex_pred_taken) ||
                       (actual_taken && (ex_pred_target != target[PC_W-1:0])));

  assign upd_en   = ex_valid && (ex_branch || ex_jal || ex_jalr) && !halted;
  assign redirect = mispredict || (ex_valid && ex_halt) || halted;

  always_comb begin
    redirect_pc = pc_four;
    if (halted) begin
      redirect_pc = {{(32-PC_W){1'b0}}, halt_pc_q};
    end else if (ex_valid && ex_halt) begin
      redirect_pc = ex_pc_ext;
    end else if (actual_taken) begin
      redirect_pc = target;
    end
  end

  always_comb begin
    state_d   = state_q;
    halt_pc_d = halt_pc_q;
    case (state_q)
      RUN: begin
        if (ex_valid && ex_halt) begin
          state_d   = HALTED;
          halt_pc_d = ex_pc;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      halt_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      halt_pc_q <= halt_pc_d;
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_en && (br_cnt_q != 32'hFFFF_FFFF)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (mispredict && !halted && (mis_cnt_q != 32'hFFFF_FFFF)) begin
      mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - self-checking bench for branch_predict_unit
// (vector table, corner sequences, randomized run against a reference model).
module tb_branch_predict_unit;

  localparam int PC_W    = 9;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [PC_W-1:0] fetch_pc, pred_target, ex_pc, ex_pred_target;
  logic            pred_taken, ex_valid, ex_branch, ex_jal, ex_jalr, ex_halt;
  logic            ex_pred_taken, redirect, j_sel, halted;
  logic [31:0]     ex_imm, ex_alu_result, pc_four, redirect_pc;
`ifdef BPU_PERF_CNT_EN
  logic [31:0]     br_cnt, mis_cnt;
`endif

  always #5 clk = ~clk;

  branch_predict_unit #(.PC_W(PC_W), .ENTRIES(ENTRIES)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_branch      (ex_branch),
    .ex_jal         (ex_jal),
    .ex_jalr        (ex_jalr),
    .ex_halt        (ex_halt),
    .ex_alu_result  (ex_alu_result),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc_four        (pc_four),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .j_sel          (j_sel),
    .halted         (halted)
`ifdef BPU_PERF_CNT_EN
    ,
    .br_cnt         (br_cnt),
    .mis_cnt        (mis_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: plain arrays of small integers.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_halted;
  int unsigned m_halt_pc;
  longint unsigned m_br, m_mis;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int m_idx(input int unsigned pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input int unsigned pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 1;
    end
    m_halted  = 1'b0;
    m_halt_pc = 0;
    m_br      = 0;
    m_mis     = 0;
  endtask

  function automatic int unsigned m_target32();
    if (ex_jalr) return ex_alu_result;
    return 32'(ex_pc) + ex_imm;
  endfunction

  function automatic bit m_actual();
    return (ex_branch && ex_alu_result[0]) || ex_jal || ex_jalr;
  endfunction

  function automatic bit m_mispredict();
    int unsigned tpc;
    bit act;
    tpc = m_target32() % (1 << PC_W);
    act = m_actual();
    return ex_valid && ((act != ex_pred_taken) || (act && (ex_pred_target != tpc)));
  endfunction

  task automatic model_check(input string nm);
    int fi;
    bit hit, act, red;
    int unsigned t32, rpc;
    fi  = m_idx(fetch_pc);
    hit = m_valid[fi] && (m_tag[fi] == m_tagof(fetch_pc));
    t32 = m_target32();
    act = m_actual();
    red = m_mispredict() || (ex_valid && ex_halt) || m_halted;
    if (m_halted) rpc = m_halt_pc;
    else if (ex_valid && ex_halt) rpc = ex_pc;
    else if (act) rpc = t32;
    else rpc = 32'(ex_pc) + 4;
    check({nm, ".pred_taken"}, pred_taken, hit && (m_ctr[fi] >= 2) && !m_halted);
    check({nm, ".pred_target"}, pred_target, hit ? m_tgt[fi] : 0);
    check({nm, ".redirect"}, redirect, red);
    if (red) check({nm, ".redirect_pc"}, redirect_pc, rpc);
    check({nm, ".pc_four"}, pc_four, 32'(ex_pc) + 32'd4);
    check({nm, ".j_sel"}, j_sel, ex_jal || ex_jalr);
    check({nm, ".halted"}, halted, m_halted);
`ifdef BPU_PERF_CNT_EN
    check({nm, ".br_cnt"}, br_cnt, m_br);
    check({nm, ".mis_cnt"}, mis_cnt, m_mis);
`endif
  endtask

  // Applies the inputs sampled at the edge that just happened.
  task automatic model_step();
    int ei;
    bit hit, act;
    int unsigned tpc;
    if (m_halted) return;
    ei  = m_idx(ex_pc);
    hit = m_valid[ei] && (m_tag[ei] == m_tagof(ex_pc));
    act = m_actual();
    tpc = m_target32() % (1 << PC_W);
    if (m_mispredict() && m_mis < 64'hFFFF_FFFF) m_mis++;
    if (ex_valid && (ex_branch || ex_jal || ex_jalr)) begin
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (hit) begin
        m_ctr[ei] = act ? ((m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3)
                        : ((m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0);
        if (act) m_tgt[ei] = tpc;
      end else if (act) begin
        m_valid[ei] = 1'b1;
        m_tag[ei]   = m_tagof(ex_pc);
        m_tgt[ei]   = tpc;
        m_ctr[ei]   = (ex_jal || ex_jalr) ? 3 : 2;
      end
    end
    if (ex_valid && ex_halt) begin
      m_halted  = 1'b1;
      m_halt_pc = ex_pc;
    end
  endtask

  task automatic drive(input bit v, input int unsigned pc, input int unsigned imm,
                       input bit br, input bit jal, input bit jalr, input bit hlt,
                       input int unsigned alu, input bit ptk, input int unsigned ptgt,
                       input int unsigned fpc);
    ex_valid       = v;
    ex_pc          = PC_W'(pc);
    ex_imm         = imm;
    ex_branch      = br;
    ex_jal         = jal;
    ex_jalr        = jalr;
    ex_halt        = hlt;
    ex_alu_result  = alu;
    ex_pred_taken  = ptk;
    ex_pred_target = PC_W'(ptgt);
    fetch_pc       = PC_W'(fpc);
  endtask

  task automatic idle(input int unsigned fpc);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, fpc);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic finish_cycle(input string nm);
    model_check(nm);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit v; int unsigned pc, imm; bit br, jal, jalr, hlt; int unsigned alu;
    bit ptk; int unsigned ptgt, fpc;
    bit e_pt; int unsigned e_ptgt; bit e_red; int unsigned e_rpc, e_pc4; bit e_js;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 'h040, 'h0,  1'b0,1'b0,1'b0,1'b0, 'h0,   1'b0, 'h0,   'h040, 1'b0, 'h0,   1'b0, 'h0,   'h044, 1'b0};
    vecs[1]  = '{1'b1, 'h040, 'h20, 1'b1,1'b0,1'b0,1'b0, 'h1,   1'b0, 'h0,   'h040, 1'b0, 'h0,   1'b1, 'h060, 'h044, 1'b0};
    vecs[2]  = '{1'b1, 'h040, 'h20, 1'b1,1'b0,1'b0,1'b0, 'h1,   1'b1, 'h060, 'h040, 1'b1, 'h060, 1'b0, 'h0,   'h044, 1'b0};
    vecs[3]  = '{1'b1, 'h040, 'h20, 1'b1,1'b0,1'b0,1'b0, 'h1,   1'b1, 'h060, 'h040, 1'b1, 'h060, 1'b0, 'h0,   'h044, 1'b0};
    vecs[4]  = '{1'b1, 'h040, 'h20, 1'b1,1'b0,1'b0,1'b0, 'h0,   1'b1, 'h060, 'h040, 1'b1, 'h060, 1'b1, 'h044, 'h044, 1'b0};
    vecs[5]  = '{1'b0, 'h040, 'h0,  1'b0,1'b0,1'b0,1'b0, 'h0,   1'b0, 'h0,   'h040, 1'b1, 'h060, 1'b0, 'h0,   'h044, 1'b0};
    vecs[6]  = '{1'b1, 'h100, 'h0,  1'b0,1'b0,1'b1,1'b0, 'h1F0, 1'b1, 'h1EC, 'h100, 1'b0, 'h0,   1'b1, 'h1F0, 'h104, 1'b1};
    vecs[7]  = '{1'b0, 'h100, 'h0,  1'b0,1'b0,1'b0,1'b0, 'h0,   1'b0, 'h0,   'h100, 1'b1, 'h1F0, 1'b0, 'h0,   'h104, 1'b0};
    vecs[8]  = '{1'b1, 'h1F0, 'h10, 1'b1,1'b0,1'b0,1'b0, 'h1,   1'b0, 'h0,   'h040, 1'b0, 'h0,   1'b1, 'h200, 'h1F4, 1'b0};
    vecs[9]  = '{1'b1, 'h010, 'hFFFFFFF0, 1'b1,1'b0,1'b0,1'b0, 'h1, 1'b1, 'h0, 'h1F0, 1'b1, 'h0,   1'b0, 'h0,   'h014, 1'b0};
    vecs[10] = '{1'b0, 'h010, 'h0,  1'b0,1'b0,1'b0,1'b0, 'h0,   1'b0, 'h0,   'h010, 1'b1, 'h0,   1'b0, 'h0,   'h014, 1'b0};
    vecs[11] = '{1'b1, 'h080, 'h40, 1'b0,1'b1,1'b0,1'b0, 'h0,   1'b0, 'h0,   'h100, 1'b1, 'h1F0, 1'b1, 'h0C0, 'h084, 1'b1};
    vecs[12] = '{1'b0, 'h080, 'h0,  1'b0,1'b0,1'b0,1'b0, 'h0,   1'b0, 'h0,   'h080, 1'b1, 'h0C0, 1'b0, 'h0,   'h084, 1'b0};
    vecs[13] = '{1'b1, 'h080, 'h40, 1'b1,1'b0,1'b0,1'b0, 'h0,   1'b1, 'h0C0, 'h080, 1'b1, 'h0C0, 1'b1, 'h084, 'h084, 1'b0};
    vecs[14] = '{1'b0, 'h080, 'h0,  1'b0,1'b0,1'b0,1'b0, 'h0,   1'b0, 'h0,   'h080, 1'b1, 'h0C0, 1'b0, 'h0,   'h084, 1'b0};

    reset = 1'b1;
    idle('h040);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("in_reset.pred_taken", pred_taken, 0);
    check("in_reset.halted", halted, 0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].imm, vecs[i].br, vecs[i].jal, vecs[i].jalr,
            vecs[i].hlt, vecs[i].alu, vecs[i].ptk, vecs[i].ptgt, vecs[i].fpc);
      settle();
      check($sformatf("vec%0d.pred_taken", i), pred_taken, vecs[i].e_pt);
      check($sformatf("vec%0d.pred_target", i), pred_target, vecs[i].e_ptgt);
      check($sformatf("vec%0d.redirect", i), redirect, vecs[i].e_red);
      if (vecs[i].e_red) check($sformatf("vec%0d.redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      check($sformatf("vec%0d.pc_four", i), pc_four, vecs[i].e_pc4);
      check($sformatf("vec%0d.j_sel", i), j_sel, vecs[i].e_js);
      check($sformatf("vec%0d.halted", i), halted, 0);
      finish_cycle($sformatf("vec%0d", i));
    end

    // Index 3: lookup and update in the same cycle see the old entry.
    drive(1'b1, 'h00C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 'h00C);
    settle();
    check("idx3_alloc.pred_taken", pred_taken, 0);
    finish_cycle("idx3_alloc");
    drive(1'b1, 'h00C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 'h014, 'h00C);
    settle();
    check("idx3_same_cycle.pred_taken", pred_taken, 1);
    check("idx3_same_cycle.pred_target", pred_target, 'h014);
    finish_cycle("idx3_same_cycle");
    idle('h00C);
    settle();
    check("idx3_after.pred_taken", pred_taken, 0);
    check("idx3_after.pred_target", pred_target, 'h014);
    finish_cycle("idx3_after");

    // Drive counter to STRONG_NT, push past it, then climb back by one.
    repeat (2) begin
      drive(1'b1, 'h00C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 'h00C);
      settle();
      finish_cycle("sat_nt_dec");
    end
    drive(1'b1, 'h00C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 'h00C);
    settle();
    finish_cycle("sat_nt_inc");
    idle('h00C);
    settle();
    check("sat_strong_nt.pred_taken", pred_taken, 0);
    finish_cycle("sat_strong_nt");

    // Reset asserted mid-cycle with a pending allocate.
    drive(1'b1, 'h020, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 'h080);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async.pred_taken", pred_taken, 0);
    check("reset_async.pred_target", pred_target, 0);
    check("reset_async.redirect", redirect, 1);
    check("reset_async.halted", halted, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle('h020);
    settle();
    check("reset_no_write.pred_target", pred_target, 0);
    finish_cycle("reset_no_write");

    for (int n = 0; n < 400; n++) begin
      int unsigned r, pc, imm, alu, fpc, ptgt;
      bit v, br, jal, jalr, ptk, hit;
      int ei;
      r    = $urandom_range(0, 9);
      pc   = $urandom_range(0, 47) * 4;
      fpc  = $urandom_range(0, 47) * 4;
      imm  = $urandom_range(0, 63) * 4 - 128;
      v    = ($urandom_range(0, 7) != 0);
      br   = (r >= 2) && (r <= 6);
      jal  = (r == 7);
      jalr = (r == 8);
      if (jalr) alu = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 127) * 4;
      else alu = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        ei   = m_idx(pc);
        hit  = m_valid[ei] && (m_tag[ei] == m_tagof(pc));
        ptk  = hit && (m_ctr[ei] >= 2);
        ptgt = hit ? m_tgt[ei] : 0;
      end else begin
        ptk  = ($urandom_range(0, 1) == 1);
        ptgt = $urandom_range(0, 127) * 4;
      end
      drive(v, pc, imm, br, jal, jalr, 1'b0, alu, ptk, ptgt, fpc);
      settle();
      finish_cycle($sformatf("rand%0d", n));
    end

    // Halt: sticky redirect to the halt PC and no table writes until reset.
    do_reset();
    drive(1'b1, 'h0A8, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 'h040);
    settle();
    check("halt_enter.redirect", redirect, 1);
    check("halt_enter.redirect_pc", redirect_pc, 'h0A8);
    check("halt_enter.halted", halted, 0);
    finish_cycle("halt_enter");
    drive(1'b1, 'h040, 'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 'h040);
    settle();
    check("halt_br.halted", halted, 1);
    check("halt_br.redirect", redirect, 1);
    check("halt_br.redirect_pc", redirect_pc, 'h0A8);
    check("halt_br.pred_taken", pred_taken, 0);
    finish_cycle("halt_br");
    drive(1'b1, 'h100, 'h40, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 'h040);
    settle();
    check("halt_no_update.pred_target", pred_target, 0);
    check("halt_jal.j_sel", j_sel, 1);
    check("halt_jal.pc_four", pc_four, 'h104);
    check("halt_jal.redirect_pc", redirect_pc, 'h0A8);
    finish_cycle("halt_jal");
    idle('h100);
    settle();
    check("halt_idle.redirect", redirect, 1);
    check("halt_idle.pred_target", pred_target, 0);
    finish_cycle("halt_idle");
    reset = 1'b1;
    #1;
    check("halt_reset.halted", halted, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle('h040);
    settle();
    check("run_after_reset.redirect", redirect, 0);
    finish_cycle("run_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
